// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multicycle control slice: FSM states,
// instruction classes, opcode/funct encodings, ALU codes and pc_src encodings.
package mips_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      CLS_NONE = 3'd0,
      CLS_RALU = 3'd1,
      CLS_IALU = 3'd2,
      CLS_LW   = 3'd3,
      CLS_SW   = 3'd4,
      CLS_J    = 3'd5,
      CLS_JR   = 3'd6,
      CLS_BEQ  = 3'd7
   } instr_class_t;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   // Base ALU codes; zero-extended to the ALU_OP_W port width at the top
   localparam int         ALU_CODE_W = 4;
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_AND  = 4'd1;
   localparam logic [3:0] ALU_OR   = 4'd2;
   localparam logic [3:0] ALU_NOR  = 4'd3;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SUB  = 4'd7;
   localparam logic [3:0] ALU_SUBU = 4'd8;
   localparam logic [3:0] ALU_NOP  = 4'hF;

   // pc_src encodings
   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_JUMP   = 2'b01;
   localparam logic [1:0] PC_REG    = 2'b10;
   localparam logic [1:0] PC_BRANCH = 2'b11;

endpackage

// File: rtl/mips_instr_class_dec.sv
// Combinational opcode/funct classifier. Produces the instruction class,
// the base ALU code for that instruction and an illegal-encoding flag.
// Kept standalone so the hazard unit can reuse the same decode.
module mips_instr_class_dec
   import mips_pkg::*;
(
   input  logic [5:0]            opcode,
   input  logic [5:0]            funct,
   output instr_class_t          cls,
   output logic [ALU_CODE_W-1:0] alu_code,
   output logic                  illegal
);

   // Map the encoding to a class; anything unrecognised flags illegal
   always_comb begin
      cls      = CLS_NONE;
      alu_code = ALU_NOP;
      illegal  = 1'b0;
      unique case (opcode)
         OP_RTYPE: begin
            cls = CLS_RALU;
            unique case (funct)
               FN_ADD:  alu_code = ALU_ADD;
               FN_AND:  alu_code = ALU_AND;
               FN_OR:   alu_code = ALU_OR;
               FN_NOR:  alu_code = ALU_NOR;
               FN_SLT:  alu_code = ALU_SLT;
               FN_SUB:  alu_code = ALU_SUB;
               FN_SUBU: alu_code = ALU_SUBU;
               FN_JR:   cls      = CLS_JR;
               default: begin
                  cls     = CLS_NONE;
                  illegal = 1'b1;
               end
            endcase
         end
         OP_ADDI: begin cls = CLS_IALU; alu_code = ALU_ADD; end
         OP_ANDI: begin cls = CLS_IALU; alu_code = ALU_AND; end
         OP_ORI:  begin cls = CLS_IALU; alu_code = ALU_OR;  end
         OP_SLTI: begin cls = CLS_IALU; alu_code = ALU_SLT; end
         OP_LW:   begin cls = CLS_LW;   alu_code = ALU_ADD; end
         OP_SW:   begin cls = CLS_SW;   alu_code = ALU_ADD; end
         OP_BEQ:  begin cls = CLS_BEQ;  alu_code = ALU_SUB; end
         OP_J:    cls = CLS_J;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB/ERR with a
// req/ready handshake to a shared memory, a bounded memory wait (ERR is
// sticky until reset) and run/halt gating at instruction boundaries.
// Optional: define PERF_CNT_EN to add cycle_cnt / retired_cnt outputs.
module mips_multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int ALU_OP_W = 4,
   parameter int TIMEOUT  = 16,
   parameter int CNT_W    = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                ir_write,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic                reg_write,
   output logic                reg_dst,
   output logic                alu_src,
   output logic                mem_to_reg,
   output logic [ALU_OP_W-1:0] alu_op,
`ifdef PERF_CNT_EN
   output logic [CNT_W-1:0]    cycle_cnt,
   output logic [CNT_W-1:0]    retired_cnt,
`endif
   output logic                instr_done,
   output logic                illegal,
   output logic                timeout_err
);

   localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t                state, state_nx;
   instr_class_t          class_q, dec_class;
   logic [ALU_CODE_W-1:0] alu_code_q, dec_alu_code;
   logic                  dec_illegal;
   logic [WAIT_W-1:0]     wait_cnt;
   logic                  wait_expired;
   logic                  in_mem_phase;

   mips_instr_class_dec u_dec (
      .opcode   (opcode),
      .funct    (funct),
      .cls      (dec_class),
      .alu_code (dec_alu_code),
      .illegal  (dec_illegal)
   );

   assign in_mem_phase = (state == S_FETCH) || (state == S_MEM);
   assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));

   // State register plus the class latched in DECODE
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         class_q    <= CLS_NONE;
         alu_code_q <= ALU_NOP;
      end else begin
         state <= state_nx;
         if (state == S_DECODE) begin
            class_q    <= dec_class;
            alu_code_q <= dec_alu_code;
         end
      end
   end

   // Memory wait counter: zero outside FETCH/MEM and after each completed access
   always_ff @(posedge clk) begin
      if (reset || !in_mem_phase || mem_ready)
         wait_cnt <= '0;
      else if (!wait_expired)
         wait_cnt <= wait_cnt + 1'b1;
   end

   // Next-state logic; run is consulted only in IDLE, at retire and on illegal decode
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:   if (run) state_nx = S_FETCH;
         S_FETCH: begin
            if (mem_ready)         state_nx = S_DECODE;
            else if (wait_expired) state_nx = S_ERR;
         end
         S_DECODE: begin
            if (dec_illegal) state_nx = run ? S_FETCH : S_IDLE;
            else             state_nx = S_EXEC;
         end
         S_EXEC: begin
            unique case (class_q)
               CLS_J, CLS_JR, CLS_BEQ: state_nx = run ? S_FETCH : S_IDLE;
               CLS_LW, CLS_SW:         state_nx = S_MEM;
               CLS_RALU, CLS_IALU:     state_nx = S_WB;
               default:                state_nx = S_IDLE;
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               if (class_q == CLS_SW) state_nx = run ? S_FETCH : S_IDLE;
               else                   state_nx = S_WB;
            end else if (wait_expired) begin
               state_nx = S_ERR;
            end
         end
         S_WB:     state_nx = run ? S_FETCH : S_IDLE;
         S_ERR:    state_nx = S_ERR;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Control outputs from state and latched class (plus the memory handshake)
   always_comb begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = PC_SEQ;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      alu_src     = 1'b0;
      mem_to_reg  = 1'b0;
      alu_op      = '1;
      instr_done  = 1'b0;
      illegal     = 1'b0;
      timeout_err = 1'b0;
      unique case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               pc_src   = PC_SEQ;
            end
         end
         // illegal is driven from the IR contents, which are registered
         S_DECODE: illegal = dec_illegal;
         S_EXEC: begin
            unique case (class_q)
               CLS_RALU: alu_op = ALU_OP_W'(alu_code_q);
               CLS_IALU, CLS_LW, CLS_SW: begin
                  alu_src = 1'b1;
                  alu_op  = ALU_OP_W'(alu_code_q);
               end
               CLS_J: begin
                  pc_write   = 1'b1;
                  pc_src     = PC_JUMP;
                  instr_done = 1'b1;
               end
               CLS_JR: begin
                  pc_write   = 1'b1;
                  pc_src     = PC_REG;
                  instr_done = 1'b1;
               end
               CLS_BEQ: begin
                  alu_op     = ALU_OP_W'(ALU_SUB);
                  pc_write   = zero;
                  pc_src     = PC_BRANCH;
                  instr_done = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            mem_req    = 1'b1;
            mem_we     = (class_q == CLS_SW);
            instr_done = mem_ready && (class_q == CLS_SW);
         end
         S_WB: begin
            reg_write  = 1'b1;
            reg_dst    = (class_q == CLS_RALU);
            mem_to_reg = (class_q == CLS_LW);
            instr_done = 1'b1;
         end
         S_ERR:   timeout_err = 1'b1;
         default: ;
      endcase
   end

`ifdef PERF_CNT_EN
   // Active-cycle and retired-instruction counters, wrapping naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt   <= '0;
         retired_cnt <= '0;
      end else begin
         if (state != S_IDLE && state != S_ERR) cycle_cnt <= cycle_cnt + 1'b1;
         if (instr_done)                        retired_cnt <= retired_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: cycle-by-cycle expected control
// words for add, lw with memory wait, beq taken/not-taken, j/jr, ori/sw,
// illegal opcode, memory timeout and reset during a store.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset, run, zero, mem_ready;
   logic [5:0] opcode, funct;
   logic       mem_req, mem_we, ir_write, pc_write, reg_write, reg_dst;
   logic       alu_src, mem_to_reg, instr_done, illegal, timeout_err;
   logic [1:0] pc_src;
   logic [3:0] alu_op;
`ifdef PERF_CNT_EN
   logic [31:0] cycle_cnt, retired_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   mips_multicycle_ctrl #(.ALU_OP_W(4), .TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
      .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
      .mem_to_reg(mem_to_reg), .alu_op(alu_op),
`ifdef PERF_CNT_EN
      .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt),
`endif
      .instr_done(instr_done), .illegal(illegal), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Advance one cycle and settle just after the active edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; run = 1'b0; zero = 1'b0; mem_ready = 1'b0;
      opcode = 6'h00; funct = 6'h00;
      tick; tick;
      checks++;
      if ({mem_req, mem_we, ir_write, pc_write, reg_write, instr_done, illegal, timeout_err} !== 8'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=00000000",
            {mem_req, mem_we, ir_write, pc_write, reg_write, instr_done, illegal, timeout_err});
      end
      checks++;
      if (alu_op !== 4'hF) begin failures++; $display("FAIL reset_alu_op got=%h exp=f", alu_op); end
      reset = 1'b0;
      tick;
      checks++;
      if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_idle_hold mem_req got=%b exp=0", mem_req); end
   endtask

   task automatic test_add;
      opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1; run = 1'b1;
      tick; // 1 FETCH
      checks++;
      if ({mem_req, ir_write, pc_write, pc_src} !== 5'b11100) begin
         failures++; $display("FAIL add_fetch got=%b exp=11100", {mem_req, ir_write, pc_write, pc_src});
      end
      tick; // 2 DECODE
      checks++;
      if ({mem_req, ir_write, illegal, reg_write} !== 4'b0000) begin
         failures++; $display("FAIL add_decode got=%b exp=0000", {mem_req, ir_write, illegal, reg_write});
      end
      tick; // 3 EXEC
      checks++;
      if ({alu_op, alu_src, instr_done} !== 6'b0000_0_0) begin
         failures++; $display("FAIL add_exec got=%b exp=000000", {alu_op, alu_src, instr_done});
      end
      tick; // 4 WB
      checks++;
      if ({reg_write, reg_dst, mem_to_reg, instr_done} !== 4'b1101) begin
         failures++; $display("FAIL add_wb got=%b exp=1101", {reg_write, reg_dst, mem_to_reg, instr_done});
      end
      run = 1'b0;
      tick; // IDLE
      checks++;
      if ({mem_req, instr_done} !== 2'b00) begin
         failures++; $display("FAIL add_park got=%b exp=00", {mem_req, instr_done});
      end
   endtask

   task automatic test_lw_wait;
      int held = 0;
      opcode = 6'h23; mem_ready = 1'b1; run = 1'b1;
      tick; tick; tick; // 3 EXEC
      checks++;
      if ({alu_op, alu_src} !== 5'b0000_1) begin
         failures++; $display("FAIL lw_exec got=%b exp=00001", {alu_op, alu_src});
      end
      tick; // 4 MEM
      for (int c = 4; c <= 7; c++) begin
         mem_ready = (c == 7);
         if (mem_req === 1'b1 && mem_we === 1'b0 && instr_done === 1'b0) held++;
         if (c != 7) tick;
      end
      checks++;
      if (held !== 4) begin failures++; $display("FAIL lw_mem_hold got=%0d exp=4", held); end
      tick; // 8 WB
      checks++;
      if ({reg_write, reg_dst, mem_to_reg, instr_done} !== 4'b1011) begin
         failures++; $display("FAIL lw_wb got=%b exp=1011", {reg_write, reg_dst, mem_to_reg, instr_done});
      end
      run = 1'b0;
      tick;
   endtask

   task automatic test_beq;
      opcode = 6'h04; mem_ready = 1'b1; run = 1'b1; zero = 1'b1;
      tick; tick; tick; // 3 EXEC, taken
      checks++;
      if ({pc_write, pc_src, instr_done, alu_op} !== 8'b1_11_1_0111) begin
         failures++; $display("FAIL beq_taken got=%b exp=11110111", {pc_write, pc_src, instr_done, alu_op});
      end
      tick; // 1 FETCH of the second beq
      checks++;
      if (ir_write !== 1'b1) begin failures++; $display("FAIL beq_refetch ir_write got=%b exp=1", ir_write); end
      zero = 1'b0;
      tick; tick; // 3 EXEC, not taken
      checks++;
      if ({pc_write, pc_src, instr_done} !== 4'b0111) begin
         failures++; $display("FAIL beq_not_taken got=%b exp=0111", {pc_write, pc_src, instr_done});
      end
      run = 1'b0;
      tick;
      checks++;
      if (mem_req !== 1'b0) begin failures++; $display("FAIL beq_park mem_req got=%b exp=0", mem_req); end
   endtask

   task automatic test_jumps;
      opcode = 6'h02; funct = 6'h00; mem_ready = 1'b1; run = 1'b1;
      tick; tick; tick; // 3 EXEC j
      checks++;
      if ({pc_write, pc_src, instr_done, alu_op} !== 8'b1_01_1_1111) begin
         failures++; $display("FAIL j_exec got=%b exp=10111111", {pc_write, pc_src, instr_done, alu_op});
      end
      opcode = 6'h00; funct = 6'h08;
      tick; tick; tick; // 3 EXEC jr
      checks++;
      if ({pc_write, pc_src, instr_done} !== 4'b1101) begin
         failures++; $display("FAIL jr_exec got=%b exp=1101", {pc_write, pc_src, instr_done});
      end
      run = 1'b0;
      tick;
   endtask

   task automatic test_ialu_sw;
      opcode = 6'h0D; mem_ready = 1'b1; run = 1'b1;
      tick; tick; tick; // 3 EXEC ori
      checks++;
      if ({alu_op, alu_src} !== 5'b0010_1) begin
         failures++; $display("FAIL ori_exec got=%b exp=00101", {alu_op, alu_src});
      end
      tick; // 4 WB
      checks++;
      if ({reg_write, reg_dst, mem_to_reg, instr_done} !== 4'b1001) begin
         failures++; $display("FAIL ori_wb got=%b exp=1001", {reg_write, reg_dst, mem_to_reg, instr_done});
      end
      opcode = 6'h2B;
      tick; tick; tick; // 3 EXEC sw
      checks++;
      if ({alu_op, alu_src, mem_req} !== 6'b0000_1_0) begin
         failures++; $display("FAIL sw_exec got=%b exp=000010", {alu_op, alu_src, mem_req});
      end
      tick; // 4 MEM, ready immediately -> retires here
      checks++;
      if ({mem_req, mem_we, instr_done, reg_write} !== 4'b1110) begin
         failures++; $display("FAIL sw_mem got=%b exp=1110", {mem_req, mem_we, instr_done, reg_write});
      end
      run = 1'b0;
      tick;
      checks++;
      if ({mem_req, reg_write} !== 2'b00) begin
         failures++; $display("FAIL sw_park got=%b exp=00", {mem_req, reg_write});
      end
   endtask

   task automatic test_timeout;
      int held = 0;
      opcode = 6'h00; funct = 6'h20; mem_ready = 1'b0; run = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick;
         if (mem_req === 1'b1 && timeout_err === 1'b0) held++;
      end
      checks++;
      if (held !== 16) begin failures++; $display("FAIL timeout_wait got=%0d exp=16", held); end
      tick; // ERR
      checks++;
      if ({timeout_err, mem_req, ir_write, pc_write, reg_write, instr_done, alu_op} !== 10'b100000_1111) begin
         failures++; $display("FAIL timeout_err_state got=%b exp=1000001111",
            {timeout_err, mem_req, ir_write, pc_write, reg_write, instr_done, alu_op});
      end
      mem_ready = 1'b1;
      tick; // stays in ERR despite ready
      checks++;
      if ({timeout_err, mem_req, ir_write} !== 3'b100) begin
         failures++; $display("FAIL timeout_sticky got=%b exp=100", {timeout_err, mem_req, ir_write});
      end
      reset = 1'b1; run = 1'b0;
      tick;
      checks++;
      if ({timeout_err, mem_req} !== 2'b00) begin
         failures++; $display("FAIL timeout_reset got=%b exp=00", {timeout_err, mem_req});
      end
      reset = 1'b0;
      tick;
   endtask

   task automatic test_illegal;
      opcode = 6'h3F; mem_ready = 1'b1; run = 1'b1;
      tick; tick; // 2 DECODE
      checks++;
      if ({illegal, reg_write, mem_req, ir_write, instr_done} !== 5'b10000) begin
         failures++; $display("FAIL illegal_decode got=%b exp=10000",
            {illegal, reg_write, mem_req, ir_write, instr_done});
      end
      tick; // straight back to FETCH
      checks++;
      if ({mem_req, illegal, ir_write} !== 3'b101) begin
         failures++; $display("FAIL illegal_refetch got=%b exp=101", {mem_req, illegal, ir_write});
      end
      run = 1'b0;
      tick; // DECODE again, then park
      tick;
      checks++;
      if ({mem_req, illegal} !== 2'b00) begin
         failures++; $display("FAIL illegal_park got=%b exp=00", {mem_req, illegal});
      end
   endtask

   task automatic test_reset_mid_mem;
      opcode = 6'h2B; mem_ready = 1'b1; run = 1'b1;
      tick; tick; tick; tick; // 4 MEM
      mem_ready = 1'b0;
      checks++;
      if ({mem_req, mem_we} !== 2'b11) begin
         failures++; $display("FAIL sw_mem_wait got=%b exp=11", {mem_req, mem_we});
      end
      reset = 1'b1; run = 1'b0;
      tick;
      checks++;
      if ({mem_req, mem_we, instr_done, alu_op} !== 7'b000_1111) begin
         failures++; $display("FAIL reset_mid_mem got=%b exp=0001111", {mem_req, mem_we, instr_done, alu_op});
      end
      reset = 1'b0;
      tick;
      checks++;
      if ({mem_req, instr_done} !== 2'b00) begin
         failures++; $display("FAIL reset_mid_mem_idle got=%b exp=00", {mem_req, instr_done});
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_lw_wait;
      test_beq;
      test_jumps;
      test_ialu_sw;
      test_timeout;
      test_illegal;
      test_reset_mid_mem;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
